// File: rtl/sigma_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sigma_mem_pkg
// Brief   : Shared types for the memory-port arbiter: FSM state encoding and
//           bus-master identifiers.
// Revision: 1.0  initial release
// ============================================================================
package sigma_mem_pkg;

    // Arbiter FSM states. TURN is the dead cycle between two different masters.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_CPU_ACC = 2'd2,
        ST_IOP_ACC = 2'd3
    } state_t;

    // Bus-master identifiers used for the grant decision and the winner latch.
    typedef logic [1:0] master_id_t;

    localparam master_id_t c_MST_NONE = 2'd0;
    localparam master_id_t c_MST_CPU  = 2'd1;
    localparam master_id_t c_MST_IOP  = 2'd2;

endpackage : sigma_mem_pkg
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_timer
// Brief   : Access cycle counter. Counts 0..ACCESS_CYCLES-1 while an access is
//           running and provides registered first/last-cycle flags, plus the
//           look-ahead last flag so the owner can register its done pulse.
// Revision: 1.0  initial release
// ============================================================================
module mem_arb_timer #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_start,      // next cycle is the first cycle of a new access
    input  logic i_advance,    // next cycle continues the current access
    output logic o_first,      // current cycle is the first of an access
    output logic o_last,       // current cycle is the last of an access
    output logic o_last_next   // next cycle will be the last of an access
);

    localparam int c_CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACCESS_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_running_next;
    logic               r_first;
    logic               r_last;

    // Next count: restart at zero on a new access, otherwise step forward.
    always_comb begin
        w_count_next   = '0;
        w_running_next = i_start || i_advance;
        if (i_advance && !i_start) begin
            w_count_next = r_count + 1'b1;
        end
        o_last_next = w_running_next && (w_count_next == c_CNT_LAST);
    end

    // Count and flag registers; an asynchronous reset aborts any access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_first <= i_start;
            r_last  <= o_last_next;
        end
    end

    assign o_first = r_first;
    assign o_last  = r_last;

endmodule : mem_arb_timer
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-master memory-port arbiter (IOP and CPU). Grants whole,
//           fixed-length accesses, inserts one dead cycle when ownership
//           changes, gives the IOP priority with a starvation bound for the
//           CPU, and honours a CPU read-modify-write lock.
// Revision: 1.0  initial release
// ============================================================================
module mem_arbiter
    import sigma_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int IOP_BURST_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_req,
    input  logic cpu_lock,
    input  logic iop_req,
    output logic cpu_active,
    output logic iop_active,
    output logic cpu_done,
    output logic iop_done,
    output logic mem_start
);

    localparam int c_STREAK_W = $clog2(IOP_BURST_MAX + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_SAT = c_STREAK_W'(IOP_BURST_MAX);

    state_t                  r_state;
    state_t                  w_next_state;
    master_id_t              r_winner;
    master_id_t              w_winner_next;
    master_id_t              w_decision;
    master_id_t              w_grant;
    logic [c_STREAK_W-1:0]   r_streak;
    logic [c_STREAK_W-1:0]   w_streak_next;

    logic                    w_in_acc;
    logic                    w_next_in_acc;
    logic                    w_start;
    logic                    w_advance;
    logic                    w_first;
    logic                    w_last;
    logic                    w_last_next;

    logic                    r_cpu_active;
    logic                    r_iop_active;
    logic                    r_cpu_done;
    logic                    r_iop_done;

    // Access timer: restarted on every new grant, advanced inside an access.
    mem_arb_timer #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .i_start     (w_start),
        .i_advance   (w_advance),
        .o_first     (w_first),
        .o_last      (w_last),
        .o_last_next (w_last_next)
    );

    // Who would win if this edge were a decision edge (priority order).
    always_comb begin
        w_decision = c_MST_NONE;
        if ((r_state == ST_CPU_ACC) && cpu_lock && cpu_req) begin
            w_decision = c_MST_CPU;            // RMW lock keeps the bus
        end else if ((r_streak == c_STREAK_SAT) && cpu_req) begin
            w_decision = c_MST_CPU;            // CPU has waited long enough
        end else if (iop_req) begin
            w_decision = c_MST_IOP;
        end else if (cpu_req) begin
            w_decision = c_MST_CPU;
        end
    end

    // Next-state logic: decisions only in IDLE or at the end of an access.
    always_comb begin
        w_next_state  = r_state;
        w_winner_next = r_winner;
        w_grant       = c_MST_NONE;
        case (r_state)
            ST_IDLE: begin
                w_grant = w_decision;
                // Both drivers are already off, so no dead cycle is needed.
                if (w_decision == c_MST_CPU) begin
                    w_next_state = ST_CPU_ACC;
                end else if (w_decision == c_MST_IOP) begin
                    w_next_state = ST_IOP_ACC;
                end
            end
            ST_CPU_ACC: begin
                if (w_last) begin
                    w_grant = w_decision;
                    if (w_decision == c_MST_NONE) begin
                        w_next_state = ST_IDLE;
                    end else if (w_decision == c_MST_IOP) begin
                        w_next_state  = ST_TURN;
                        w_winner_next = c_MST_IOP;
                    end
                end
            end
            ST_IOP_ACC: begin
                if (w_last) begin
                    w_grant = w_decision;
                    if (w_decision == c_MST_NONE) begin
                        w_next_state = ST_IDLE;
                    end else if (w_decision == c_MST_CPU) begin
                        w_next_state  = ST_TURN;
                        w_winner_next = c_MST_CPU;
                    end
                end
            end
            ST_TURN: begin
                // Winner was latched on entry; requests are not looked at here.
                w_next_state = (r_winner == c_MST_CPU) ? ST_CPU_ACC : ST_IOP_ACC;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Timer control and IOP streak update derived from the grant.
    always_comb begin
        w_in_acc      = (r_state == ST_CPU_ACC) || (r_state == ST_IOP_ACC);
        w_next_in_acc = (w_next_state == ST_CPU_ACC) || (w_next_state == ST_IOP_ACC);
        w_start       = w_next_in_acc && (!w_in_acc || w_last);
        w_advance     = w_in_acc && !w_last;

        w_streak_next = r_streak;
        if (w_grant == c_MST_CPU) begin
            w_streak_next = '0;
        end else if (w_grant == c_MST_IOP) begin
            if (!cpu_req) begin
                w_streak_next = '0;
            end else if (r_streak != c_STREAK_SAT) begin
                w_streak_next = r_streak + 1'b1;
            end
        end
    end

    // State, winner latch, streak counter and registered bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_winner     <= c_MST_NONE;
            r_streak     <= '0;
            r_cpu_active <= 1'b0;
            r_iop_active <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_iop_done   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_winner     <= w_winner_next;
            r_streak     <= w_streak_next;
            r_cpu_active <= (w_next_state == ST_CPU_ACC);
            r_iop_active <= (w_next_state == ST_IOP_ACC);
            r_cpu_done   <= (w_next_state == ST_CPU_ACC) && w_last_next;
            r_iop_done   <= (w_next_state == ST_IOP_ACC) && w_last_next;
        end
    end

    assign cpu_active = r_cpu_active;
    assign iop_active = r_iop_active;
    assign cpu_done   = r_cpu_done;
    assign iop_done   = r_iop_done;
    assign mem_start  = w_first;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter. A behavioural model tracks
//           the bus owner, cycles left in the access and a pending owner
//           after a dead cycle; directed scenarios and random traffic are
//           compared against it every cycle.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AC = 2;
    localparam int BM = 4;

    logic clock = 1'b0;
    logic reset;
    logic cpu_req;
    logic cpu_lock;
    logic iop_req;
    logic cpu_active;
    logic iop_active;
    logic cpu_done;
    logic iop_done;
    logic mem_start;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner 0=none 1=CPU 2=IOP, cycles left in access, owner after a dead cycle.
    int m_owner  = 0;
    int m_left   = 0;
    int m_next   = 0;
    int m_streak = 0;

    mem_arbiter #(
        .ACCESS_CYCLES (AC),
        .IOP_BURST_MAX (BM)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_lock   (cpu_lock),
        .iop_req    (iop_req),
        .cpu_active (cpu_active),
        .iop_active (iop_active),
        .cpu_done   (cpu_done),
        .iop_done   (iop_done),
        .mem_start  (mem_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_left   = 0;
        m_next   = 0;
        m_streak = 0;
    endtask

    // One rising edge of the reference model, using the inputs seen at that edge.
    task automatic model_edge();
        int prev;
        int win;
        if (reset) begin
            model_reset();
        end else if (m_next != 0) begin
            m_owner = m_next;
            m_left  = AC;
            m_next  = 0;
        end else if (m_owner == 0 || m_left == 1) begin
            prev = m_owner;
            if (prev == 1 && cpu_lock && cpu_req)   win = 1;
            else if (m_streak == BM && cpu_req)     win = 1;
            else if (iop_req)                       win = 2;
            else if (cpu_req)                       win = 1;
            else                                    win = 0;
            if (win == 1)      m_streak = 0;
            else if (win == 2) m_streak = cpu_req ? ((m_streak < BM) ? m_streak + 1 : BM) : 0;
            if (win == 0) begin
                m_owner = 0;
                m_left  = 0;
            end else if (prev == 0 || win == prev) begin
                m_owner = win;
                m_left  = AC;
            end else begin
                m_owner = 0;
                m_left  = 0;
                m_next  = win;
            end
        end else begin
            m_left--;
        end
    endtask

    task automatic check_outputs();
        check("cpu_active", 32'(cpu_active), 32'(m_owner == 1));
        check("iop_active", 32'(iop_active), 32'(m_owner == 2));
        check("mem_start",  32'(mem_start),  32'(m_owner != 0 && m_left == AC));
        check("cpu_done",   32'(cpu_done),   32'(m_owner == 1 && m_left == 1));
        check("iop_done",   32'(iop_done),   32'(m_owner == 2 && m_left == 1));
        check("exclusive",  32'(cpu_active & iop_active), 32'd0);
    endtask

    // Advance one clock; inputs are changed by the caller after this returns.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_req(input logic c, input logic l, input logic i);
        cpu_req  = c;
        cpu_lock = l;
        iop_req  = i;
    endtask

    // Assert reset between edges, confirm outputs drop at once, hold, release.
    task automatic async_reset(input int hold_cycles, input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_cpu_act"}, 32'(cpu_active), 32'd0);
        check({tag, "_iop_act"}, 32'(iop_active), 32'd0);
        check({tag, "_outs"}, 32'({cpu_done, iop_done, mem_start}), 32'd0);
        for (int k = 0; k < hold_cycles; k++) begin
            set_req(1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        string seq;
        string exp_seq;
        int    n_starts;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0);

        // Reset held with random requests: everything stays low.
        for (int k = 0; k < 4; k++) begin
            set_req(1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        set_req(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Single CPU access from idle.
        set_req(1'b1, 1'b0, 1'b0);
        step();
        check("single_cpu_c1_active", 32'(cpu_active), 32'd1);
        check("single_cpu_c1_start",  32'(mem_start),  32'd1);
        set_req(1'b0, 1'b0, 1'b0);
        step();
        check("single_cpu_c2_done", 32'(cpu_done), 32'd1);
        step();
        check("single_cpu_c3_idle", 32'(cpu_active), 32'd0);
        step();

        // Simultaneous requests: IOP first, dead cycle, then CPU.
        set_req(1'b1, 1'b0, 1'b1);
        step();
        check("both_c1_iop", 32'(iop_active), 32'd1);
        step();
        set_req(1'b1, 1'b0, 1'b0);
        step();
        check("both_c3_turn", 32'({cpu_active, iop_active}), 32'd0);
        step();
        check("both_c4_cpu", 32'(cpu_active), 32'd1);
        set_req(1'b0, 1'b0, 1'b0);
        step();
        step();

        // Starvation bound: 4 IOP accesses, then one CPU access, repeating.
        async_reset(1, "pre_starve");
        set_req(1'b1, 1'b0, 1'b1);
        seq = "";
        n_starts = 0;
        for (int k = 0; k < 60 && n_starts < 10; k++) begin
            step();
            if (mem_start) begin
                seq = {seq, cpu_active ? "C" : "I"};
                n_starts++;
            end
        end
        exp_seq = "IIIICIIIIC";
        check("starve_count", 32'(n_starts), 32'd10);
        for (int k = 0; k < 10 && k < seq.len(); k++) begin
            check($sformatf("starve_grant%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
        end
        set_req(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step();

        // CPU lock: second CPU access follows with no dead cycle.
        set_req(1'b1, 1'b0, 1'b0);
        step();
        step();
        set_req(1'b1, 1'b1, 1'b1);
        step();
        check("lock_again_start", 32'({cpu_active, mem_start}), 32'd3);
        set_req(1'b0, 1'b0, 1'b1);
        step();
        step();
        check("lock_then_turn", 32'({cpu_active, iop_active}), 32'd0);
        step();
        check("lock_then_iop", 32'(iop_active), 32'd1);
        set_req(1'b0, 1'b0, 1'b0);
        step();
        step();

        // Reset during the first cycle of an IOP access, then a fresh access.
        set_req(1'b0, 1'b0, 1'b1);
        step();
        check("rst_pre_iop", 32'(iop_active), 32'd1);
        async_reset(2, "mid_iop");
        set_req(1'b0, 1'b0, 1'b1);
        step();
        check("rst_fresh_start", 32'({iop_active, mem_start}), 32'd3);
        set_req(1'b0, 1'b0, 1'b0);
        step();
        check("rst_fresh_done", 32'(iop_done), 32'd1);
        step();

        // Random traffic with occasional asynchronous resets.
        for (int k = 0; k < 1500; k++) begin
            set_req(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 30),
                    ($urandom_range(0, 99) < 60));
            if ($urandom_range(0, 249) == 0) begin
                async_reset(int'($urandom_range(1, 3)), "rand_rst");
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
